// File: rtl/pio_svc_pkg.sv
// Shared FSM state type and PIO slave register map for the edge-capture
// servicer and its helpers.
package pio_svc_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD,
    WAIT,
    CLR,
    GUARD
  } svc_state_e;

  localparam logic [1:0] DATA_ADDR = 2'd0;
  localparam logic [1:0] DIR_ADDR  = 2'd1;
  localparam logic [1:0] MASK_ADDR = 2'd2;
  localparam logic [1:0] EDGE_ADDR = 2'd3;

endpackage

// File: rtl/pio_evt_accum.sv
// Pending-event accumulator: ORs masked edge captures into a set, offers the
// set on a valid/ready stream and flags bits that arrive while still unconsumed.
module pio_evt_accum #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_sample,
  input  logic [DATA_WIDTH-1:0] i_captured,
  input  logic [DATA_WIDTH-1:0] i_mask,
  input  logic                  i_evt_ready,
  output logic [DATA_WIDTH-1:0] o_evt_data,
  output logic                  o_evt_valid,
  output logic                  o_overrun
);

  logic [DATA_WIDTH-1:0] r_pending;
  logic                  r_valid;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] w_accepted;
  logic [DATA_WIDTH-1:0] w_new;
  logic [DATA_WIDTH-1:0] w_pending_next;
  logic                  w_overrun_next;

  // Bits handed over this cycle are dropped; a capture landing in the same
  // cycle as an accept stays pending for the next event.
  always_comb begin
    w_accepted     = (r_valid && i_evt_ready) ? r_pending : '0;
    w_new          = i_sample ? (i_captured & i_mask) : '0;
    w_pending_next = (r_pending & ~w_accepted) | w_new;
    w_overrun_next = |(w_new & r_pending & ~w_accepted);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_valid   <= (w_pending_next != '0);
      r_overrun <= w_overrun_next;
    end
  end

  assign o_evt_data  = r_pending;
  assign o_evt_valid = r_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/pio_edge_irq_servicer.sv
// Avalon-MM initiator that programs a PIO slave's irq mask, then on each irq
// reads and clears its edge-capture register and streams the captured bits.
module pio_edge_irq_servicer
  import pio_svc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [1:0]  MASK_ADDR    = pio_svc_pkg::MASK_ADDR,
  parameter logic [1:0]  EDGE_ADDR    = pio_svc_pkg::EDGE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] mask_cfg,
  input  logic                  irq,
  output logic [1:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  output logic [DATA_WIDTH-1:0] evt_data,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned      CNT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  svc_state_e            r_state;
  svc_state_e            w_state_next;
  logic [CNT_W-1:0]      r_lat_cnt;
  logic [DATA_WIDTH-1:0] r_mask_shadow;
  logic                  r_cs;
  logic                  r_write_n;
  logic [1:0]            r_addr;
  logic [31:0]           r_wdata;
  logic                  r_busy;
  logic                  w_cs;
  logic                  w_write_n;
  logic [1:0]            w_addr;
  logic [31:0]           w_wdata;
  logic                  w_sample;
  logic                  w_unused_rd;

  assign w_sample    = (r_state == WAIT) && (r_lat_cnt == CNT_LAST);
  assign w_unused_rd = ^avm_readdata[31:DATA_WIDTH];

  // Bus strobes are registered: the mask write leaves INIT, while the read and
  // the clear are launched as RD and CLR are entered so they show in those states.
  always_comb begin
    w_state_next = r_state;
    w_cs         = 1'b0;
    w_write_n    = 1'b1;
    w_addr       = '0;
    w_wdata      = '0;
    case (r_state)
      INIT:  w_state_next = IDLE;
      IDLE: begin
        if (mask_cfg != r_mask_shadow) w_state_next = INIT;
        else if (irq)                  w_state_next = RD;
      end
      RD:    w_state_next = WAIT;
      WAIT:  if (r_lat_cnt == CNT_LAST) w_state_next = CLR;
      CLR:   w_state_next = GUARD;
      GUARD: w_state_next = IDLE;
      default: w_state_next = INIT;
    endcase
    if (r_state == INIT) begin
      w_cs      = 1'b1;
      w_write_n = 1'b0;
      w_addr    = MASK_ADDR;
      w_wdata   = 32'(mask_cfg);
    end else if (w_state_next == RD) begin
      w_cs   = 1'b1;
      w_addr = EDGE_ADDR;
    end else if (w_state_next == CLR) begin
      w_cs      = 1'b1;
      w_write_n = 1'b0;
      w_addr    = EDGE_ADDR;
      w_wdata   = 32'({DATA_WIDTH{1'b1}});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= INIT;
      r_lat_cnt     <= '0;
      r_mask_shadow <= '0;
      r_cs          <= 1'b0;
      r_write_n     <= 1'b1;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_busy        <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cs      <= w_cs;
      r_write_n <= w_write_n;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_busy    <= (w_state_next != IDLE);
      if (r_state == INIT) r_mask_shadow <= mask_cfg;
      if (r_state == RD)
        r_lat_cnt <= CNT_LOAD;
      else if (r_state == WAIT)
        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
    end
  end

  pio_evt_accum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_accum (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_sample   (w_sample),
    .i_captured (avm_readdata[DATA_WIDTH-1:0]),
    .i_mask     (r_mask_shadow),
    .i_evt_ready(evt_ready),
    .o_evt_data (evt_data),
    .o_evt_valid(evt_valid),
    .o_overrun  (overrun)
  );

  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_write_n;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign busy           = r_busy;

endmodule

// File: tb/tb_pio_edge_irq_servicer.sv
// Bench for pio_edge_irq_servicer: a PIO slave model plus a transaction-schedule
// reference model checked every cycle, with directed scenarios and a random soak.
module tb_pio_edge_irq_servicer;

  localparam int          LAT      = 1;
  localparam int          DEPTH    = 8;
  localparam logic [35:0] BUS_IDLE = {1'b0, 1'b1, 2'd0, 32'h0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  mask_cfg = 8'h01;
  logic        irq;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic [7:0]  evt_data;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic        overrun;
  logic        busy;

  // PIO slave model state
  logic [7:0]  sEdge = 8'h0;
  logic [7:0]  sMask = 8'h0;
  logic [7:0]  newEdges = 8'h0;
  logic [31:0] sReadData = 32'h0;

  // reference model state
  logic [35:0] expBus[DEPTH];
  logic        expBusy[DEPTH];
  logic [7:0]  mPending = 8'h0;
  logic [7:0]  mShadow = 8'h0;
  logic        mOverrun = 1'b0;
  logic        initPending = 1'b0;
  int          sampleCnt = 0;
  logic        armed = 1'b0;

  int          nChecks = 0;
  int          nFails = 0;
  int          overrunSeen = 0;
  int          validSeen = 0;
  logic [10:0] busLog[$];

  always #5 clk = ~clk;

  pio_edge_irq_servicer #(
    .DATA_WIDTH  (8),
    .READ_LATENCY(LAT),
    .MASK_ADDR   (2'd2),
    .EDGE_ADDR   (2'd3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mask_cfg      (mask_cfg),
    .irq           (irq),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .evt_data      (evt_data),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .overrun       (overrun),
    .busy          (busy)
  );

  assign irq          = (sEdge != 8'h0);
  assign avm_readdata = sReadData;

  // Slave: registered readdata, and a clear write beats a same-cycle edge.
  always @(posedge clk) begin
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2) sMask <= avm_writedata[7:0];
    if (avm_chipselect && avm_write_n && avm_address == 2'd3) sReadData <= {24'h0, sEdge};
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3) sEdge <= 8'h0;
    else sEdge <= sEdge | newEdges;
  end

  // Reference model: slot 0 of the schedule is the cycle that starts at this edge.
  always @(posedge clk) begin : model
    logic [7:0] acc;
    logic [7:0] cap;
    logic       curBusy;
    curBusy = expBusy[0];
    for (int i = 0; i < DEPTH - 1; i++) begin
      expBus[i]  = expBus[i+1];
      expBusy[i] = expBusy[i+1];
    end
    expBus[DEPTH-1]  = BUS_IDLE;
    expBusy[DEPTH-1] = 1'b0;
    armed = 1'b1;
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        expBus[i]  = BUS_IDLE;
        expBusy[i] = 1'b0;
      end
      expBusy[0]  = 1'b1;
      initPending = 1'b1;
      mPending    = 8'h0;
      mOverrun    = 1'b0;
      sampleCnt   = 0;
    end else begin
      acc      = (mPending != 8'h0 && evt_ready) ? mPending : 8'h0;
      cap      = (sampleCnt == 1) ? sReadData[7:0] : 8'h0;
      mOverrun = ((cap & mShadow & mPending & ~acc) != 8'h0);
      mPending = (mPending & ~acc) | (cap & mShadow);
      if (sampleCnt != 0) sampleCnt--;
      if (initPending) begin
        expBus[0]   = {1'b1, 1'b0, 2'd2, 24'h0, mask_cfg};
        mShadow     = mask_cfg;
        initPending = 1'b0;
      end else if (!curBusy) begin
        if (mask_cfg != mShadow) begin
          expBusy[0]  = 1'b1;
          initPending = 1'b1;
        end else if (irq) begin
          expBus[0] = {1'b1, 1'b1, 2'd3, 32'h0};
          for (int i = 0; i <= LAT + 2; i++) expBusy[i] = 1'b1;
          expBus[LAT+1] = {1'b1, 1'b0, 2'd3, 32'h0000_00FF};
          sampleCnt = LAT + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("bus", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, expBus[0]);
      checkOutput("busy", busy, expBusy[0]);
      checkOutput("evtData", evt_data, mPending);
      checkOutput("evtValid", evt_valid, mPending != 8'h0);
      checkOutput("overrun", overrun, mOverrun);
    end
  end

  function automatic logic [10:0] logAt(input int i);
    return (i < busLog.size()) ? busLog[i] : 11'h7FF;
  endfunction

  task automatic applyStimulus(input logic [7:0] mask, input logic [7:0] edges,
                               input logic ready, input int cycles);
    mask_cfg  = mask;
    newEdges  = edges;
    evt_ready = ready;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      newEdges = 8'h0;
      if (overrun) overrunSeen++;
      if (evt_valid) validSeen++;
      if (avm_chipselect) busLog.push_back({~avm_write_n, avm_address, avm_writedata[7:0]});
    end
  endtask

  initial begin
    $display("[TB] reset and mask programming");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("initWrite", {avm_chipselect, avm_write_n, avm_address, avm_writedata},
                {1'b1, 1'b0, 2'd2, 32'h1});
    @(negedge clk);
    checkOutput("idleAfterInit", {avm_chipselect, busy}, 2'b00);

    $display("[TB] single capture with consumer ready");
    busLog.delete();
    validSeen = 0;
    applyStimulus(8'h01, 8'h01, 1'b1, 8);
    checkOutput("singleValidCycles", validSeen, 1);
    checkOutput("singleRead", logAt(0), {1'b0, 2'd3, 8'h00});
    checkOutput("singleClear", logAt(1), {1'b1, 2'd3, 8'hFF});
    checkOutput("singleLogLen", busLog.size(), 2);

    $display("[TB] repeated capture while stalled");
    overrunSeen = 0;
    applyStimulus(8'h01, 8'h01, 1'b0, 8);
    applyStimulus(8'h01, 8'h01, 1'b0, 8);
    checkOutput("overrunOnce", overrunSeen, 1);
    checkOutput("stalledData", evt_data, 8'h01);
    applyStimulus(8'h01, 8'h00, 1'b1, 3);

    $display("[TB] mask change takes priority over irq");
    busLog.delete();
    applyStimulus(8'h01, 8'h01, 1'b1, 1);
    applyStimulus(8'h03, 8'h00, 1'b1, 10);
    checkOutput("maskFirst", logAt(0), {1'b1, 2'd2, 8'h03});
    checkOutput("readAfterMask", logAt(1), {1'b0, 2'd3, 8'h00});

    $display("[TB] masked-out capture");
    applyStimulus(8'h01, 8'h00, 1'b1, 5);
    busLog.delete();
    validSeen   = 0;
    overrunSeen = 0;
    applyStimulus(8'h01, 8'h02, 1'b1, 10);
    checkOutput("maskedRead", logAt(0), {1'b0, 2'd3, 8'h00});
    checkOutput("maskedClear", logAt(1), {1'b1, 2'd3, 8'hFF});
    checkOutput("maskedNoValid", validSeen, 0);
    checkOutput("maskedNoOverrun", overrunSeen, 0);

    $display("[TB] reset during read wait");
    applyStimulus(8'h01, 8'h01, 1'b0, 8);
    newEdges = 8'h01;
    @(negedge clk);
    newEdges = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rstCs", avm_chipselect, 1'b0);
    checkOutput("rstValid", evt_valid, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rstInitWrite", {avm_chipselect, avm_write_n, avm_address, avm_writedata},
                {1'b1, 1'b0, 2'd2, 32'h1});
    evt_ready = 1'b1;

    $display("[TB] random soak");
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) == 0) mask_cfg = 8'($urandom);
      newEdges  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      evt_ready = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 249) != 0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    applyStimulus(mask_cfg, 8'h00, 1'b1, 30);
    checkOutput("slaveMask", sMask, mask_cfg);
    checkOutput("drained", evt_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
